// File: rtl/booth_mult_unit_pkg.sv
// Shared definitions for the sequential Booth multiplier: state encoding,
// default operand width and the step-counter width helper.
package booth_mult_unit_pkg;

    localparam int MULT_WIDTH = 32;

    typedef logic [1:0] mult_state_t;

    localparam mult_state_t MULT_IDLE = 2'd0;
    localparam mult_state_t MULT_RUN  = 2'd1;
    localparam mult_state_t MULT_DONE = 2'd2;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int step_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator followed by an arithmetic right shift of {Acc, Q, q_1}.
module booth_step
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One guard bit keeps -2^(WIDTH-1) representable after negation.
    assign m_ext = {m_i[WIDTH-1], m_i};

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_ext;
            2'b10:   sum = acc_i - m_ext;
            default: sum = acc_i;
        endcase
    end

    assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o  = q_i[0];

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential signed multiplier for the multicycle datapath: accepts a start
// pulse in IDLE, runs WIDTH Booth steps and returns the product as hi/lo.
module booth_mult_unit
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy,
    output mult_state_t      dbg_state_o
);

    localparam int CW = step_cnt_w(WIDTH);

    // Handshake: start is a request honoured only while IDLE (operands are
    // captured on that edge); done is a one-cycle completion strobe with
    // hi/lo already valid, busy covers every non-IDLE cycle.

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic             step_q1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .q1_o  (step_q1)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MULT_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    state_d = MULT_RUN;
                end
            end
            MULT_RUN: begin
                acc_d   = step_acc;
                q_d     = step_q;
                q1_d    = step_q1;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    hi_d    = step_acc[WIDTH-1:0];
                    lo_d    = step_q;
                    state_d = MULT_DONE;
                end
            end
            MULT_DONE: state_d = MULT_IDLE;
            default:   state_d = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MULT_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= (state_d == MULT_DONE);
            busy_q  <= (state_d != MULT_IDLE);
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed and back-to-back checks of booth_mult_unit: latency, busy/done
// timing, extreme operands, ignored starts, asynchronous reset mid-run.
module tb_booth_mult_unit;
    import booth_mult_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;
    logic         busy;
    mult_state_t  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    booth_mult_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .done        (done),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered 1 time unit after the accepting edge.
    task automatic wait_done(input logic [63:0] exp, input string tag);
        int lat;
        int busy_cyc;
        logic [63:0] got;
        lat      = 0;
        busy_cyc = 0;
        got      = '0;
        done_cnt = 0;
        for (int c = 1; c <= W + 6; c++) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            if (done && lat == 0) begin
                lat = c;
                got = {hi, lo};
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_product"}, got, exp);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(W + 1));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        int lat;
        int last_done;
        int n_done;
        logic prev_done;
        logic [63:0] got;
        logic [63:0] exp;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(MULT_IDLE));
        @(negedge clk);
        reset = 1'b0;

        issue(32'd3, 32'd5);
        wait_done(64'h0000_0000_0000_000F, "p3x5");
        issue(32'hFFFF_FFF9, 32'd6);
        wait_done(64'hFFFF_FFFF_FFFF_FFD6, "m7x6");
        issue(32'h8000_0000, 32'h8000_0000);
        wait_done(64'h4000_0000_0000_0000, "min_sq");
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_done(64'h3FFF_FFFF_0000_0001, "max_sq");

        // Starts re-pulsed during RUN and DONE, operands toggled while running.
        issue(32'h0001_2345, 32'hFFFF_FFFD);
        exp      = 64'hFFFF_FFFF_FFFC_9631;
        lat      = 0;
        got      = '0;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done && lat == 0) begin
                lat = c;
                got = {hi, lo};
            end
            if (c < 32) begin
                a = $urandom;
                b = $urandom;
            end
            if (c == 5 || c == 32) start = 1'b1;
            if (c == 6 || c == 33) start = 1'b0;
        end
        check("ignore_latency", 64'(lat), 64'(W));
        check("ignore_product", got, exp);
        check("ignore_done_pulses", 64'(done_cnt), 64'd1);
        check("ignore_no_accept", 64'(busy), 64'd0);

        // Asynchronous reset ten cycles into a run.
        issue(32'd77, 32'd11);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("areset_hi", 64'(hi), 64'd0);
        check("areset_lo", 64'(lo), 64'd0);
        check("areset_done", 64'(done), 64'd0);
        check("areset_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("areset_no_done", 64'(done_cnt), 64'd0);
        check("areset_idle", 64'(busy), 64'd0);

        // Reset released with start already high: the first edge accepts.
        @(negedge clk);
        reset = 1'b1;
        a     = 32'd100;
        b     = 32'hFFFF_FF9C;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(64'hFFFF_FFFF_FFFF_D8F0, "post_reset");

        // Back-to-back starts with random operands against the reference model.
        exp_q.delete();
        prev_done = 1'b0;
        last_done = -1;
        n_done    = 0;
        a         = $urandom;
        b         = $urandom;
        start     = 1'b1;
        for (int c = 0; c < 240; c++) begin
            if (c == 200) start = 1'b0;
            if (!busy && start) exp_q.push_back(ref_prod(a, b));
            @(posedge clk);
            #1;
            if (done) begin
                check("b2b_done_width", 64'(prev_done), 64'd0);
                if (exp_q.size() > 0)
                    check("b2b_product", {hi, lo}, exp_q.pop_front());
                else
                    check("b2b_unexpected_done", 64'd1, 64'd0);
                if (last_done >= 0)
                    check("b2b_spacing", 64'(c - last_done), 64'(W + 2));
                last_done = c;
                n_done++;
            end
            prev_done = done;
            a = $urandom;
            b = $urandom;
        end
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        check("b2b_enough_ops", 64'(n_done >= 5), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
